adder_seq: RTL and testbench

Parametrised multi-cycle adder/subtractor: the sequential successor of the 16-bit combinational adder. Adds or subtracts two WIDTH-bit operands SLICE bits per clock, LSB slice first, and reports carry-out and signed overflow. A start/busy/done handshake lets a controller issue operations back-to-back. Result outputs are registered and held stable between operations.

---
 rtl/adder_seq_pkg.sv | 15 +
 rtl/adder_seq_slice.sv | 28 ++
 rtl/adder_seq.sv | 104 ++++++++++
 tb/tb_adder_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_seq_pkg.sv
// rtl/adder_seq_pkg.sv - shared state encoding and counter sizing for adder_seq
package adder_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Slice counter width: clog2 of the slice count, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_seq_slice.sv
// rtl/adder_seq_slice.sv - combinational SLICE-bit ripple adder with MSB carry-in tap
module adder_seq_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  input  logic             i_cin,
  output logic [SLICE-1:0] o_sum,
  output logic             o_cout,
  output logic             o_cmsb
);

  logic w_c;

  // The carry entering the top bit is kept separately so the caller can form signed overflow.
  always_comb begin
    w_c    = i_cin;
    o_sum  = '0;
    o_cmsb = i_cin;
    for (int i = 0; i < SLICE; i++) begin
      if (i == SLICE - 1) o_cmsb = w_c;
      o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
      w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_c;
  end

endmodule

// File: rtl/adder_seq.sv
// rtl/adder_seq.sv - multi-cycle add/subtract, SLICE bits per clock, start/busy/done handshake
module adder_seq
  import adder_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = cnt_width(N);

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_opa, r_opb, r_work, r_sum, w_work;
  logic             r_carry, r_cout, r_ovf;
  logic [CW-1:0]    r_k;
  logic [SLICE-1:0] w_a, w_b, w_s;
  logic             w_co, w_cmsb, w_run, w_last, w_accept;

  assign w_run    = (r_state == ST_RUN);
  assign w_accept = start && !w_run;
  assign w_last   = w_run && (r_k == CW'(N - 1));
  assign w_a      = r_opa[int'(r_k) * SLICE +: SLICE];
  assign w_b      = r_opb[int'(r_k) * SLICE +: SLICE];

  adder_seq_slice #(.SLICE(SLICE)) u_slice (
    .i_a   (w_a),
    .i_b   (w_b),
    .i_cin (r_carry),
    .o_sum (w_s),
    .o_cout(w_co),
    .o_cmsb(w_cmsb)
  );

  always_comb begin
    w_work = r_work;
    w_work[int'(r_k) * SLICE +: SLICE] = w_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_RUN;
      ST_RUN:  if (w_last) w_next = ST_DONE;
      ST_DONE: w_next = start ? ST_RUN : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == ST_RUN);
    done = (r_state == ST_DONE);
  end

  // Subtraction is x + ~y + 1, so cout=1 means no borrow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_work  <= '0;
      r_carry <= 1'b0;
      r_k     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_opa   <= x;
      r_opb   <= sub ? ~y : y;
      r_carry <= sub ? 1'b1 : cin;
      r_k     <= '0;
    end else if (w_run) begin
      r_work  <= w_work;
      r_carry <= w_co;
      r_k     <= r_k + 1'b1;
      if (w_last) begin
        r_sum  <= w_work;
        r_cout <= w_co;
        r_ovf  <= w_co ^ w_cmsb;
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_adder_seq.sv
// tb/tb_adder_seq.sv - self-checking bench for adder_seq (N=4 and N=1 instances)
module tb_adder_seq;

  typedef struct {
    int          inst;
    int          due;
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  start_v = 2'b00;
  logic [15:0] xv = '0, yv = '0;
  logic        cinv = 1'b0, subv = 1'b0;

  logic        busy0, done0, cout0, ovf0, busy1, done1, cout1, ovf1;
  logic [15:0] sum0, sum1;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  exp_t        q[$];
  logic [15:0] h_sum[2];
  logic        h_cout[2];
  logic        h_ovf[2];
  int          m_start[2], m_bend[2], m_next_ok[2], last_done[2], prev_done[2];

  adder_seq #(.WIDTH(16), .SLICE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .x(xv), .y(yv), .cin(cinv), .sub(subv),
    .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .ovf(ovf0)
  );

  adder_seq #(.WIDTH(16), .SLICE(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .x(xv), .y(yv), .cin(cinv), .sub(subv),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ns(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  // Reference arithmetic: {ovf, cout, sum} from plain integer math.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic ci, input logic sb);
    int unsigned full;
    logic [15:0] r;
    logic        c, o;
    if (sb) begin
      r = a - b;
      c = (a >= b);
      o = (a[15] != b[15]) && (r[15] != a[15]);
    end else begin
      full = 32'(a) + 32'(b) + 32'(ci);
      r = full[15:0];
      c = full[16];
      o = (a[15] == b[15]) && (r[15] != a[15]);
    end
    return {o, c, r};
  endfunction

  function automatic logic pending(input int i);
    foreach (q[k]) if (q[k].inst == i) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d actual=%0h expected=%0h cyc=%0d", name, i, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 2; i++) begin
      h_sum[i] = '0; h_cout[i] = 1'b0; h_ovf[i] = 1'b0;
      m_start[i] = 0; m_bend[i] = -1; m_next_ok[i] = 0;
    end
  endtask

  task automatic compare_inst(input int i);
    logic [15:0] s;
    logic        d, b, c, o, found, exp_busy;
    s = (i == 0) ? sum0 : sum1;
    d = (i == 0) ? done0 : done1;
    b = (i == 0) ? busy0 : busy1;
    c = (i == 0) ? cout0 : cout1;
    o = (i == 0) ? ovf0 : ovf1;
    found = 1'b0;
    for (int k = 0; k < q.size(); k++) begin
      if (!found && q[k].inst == i && q[k].due == cyc) begin
        h_sum[i] = q[k].s; h_cout[i] = q[k].c; h_ovf[i] = q[k].o;
        q.delete(k);
        found = 1'b1;
      end
    end
    if (found) begin
      prev_done[i] = last_done[i];
      last_done[i] = cyc;
    end
    exp_busy = (cyc >= m_start[i]) && (cyc <= m_bend[i]);
    chk("done", i, 32'(d), 32'(found));
    chk("busy", i, 32'(b), 32'(exp_busy));
    chk("sum", i, 32'(s), 32'(h_sum[i]));
    chk("cout", i, 32'(c), 32'(h_cout[i]));
    chk("ovf", i, 32'(o), 32'(h_ovf[i]));
  endtask

  always @(negedge clk) begin
    compare_inst(0);
    compare_inst(1);
  end

  // Drive one cycle; the model decides whether the DUT must accept at the coming edge.
  task automatic drive_cycle(input int i, input logic [15:0] a, input logic [15:0] b,
                             input logic ci, input logic sb, input logic st,
                             output logic acc, output int e);
    logic [17:0] r;
    exp_t        n;
    xv = a; yv = b; cinv = ci; subv = sb;
    start_v = 2'b00;
    start_v[i] = st;
    e = cyc + 1;
    acc = 1'b0;
    if (st && e >= m_next_ok[i]) begin
      r = model(a, b, ci, sb);
      n.inst = i; n.due = e + ns(i); n.s = r[15:0]; n.c = r[16]; n.o = r[17];
      q.push_back(n);
      m_start[i] = e;
      m_bend[i] = e + ns(i) - 1;
      m_next_ok[i] = e + ns(i) + 1;
      acc = 1'b1;
    end
    @(negedge clk); #1;
  endtask

  task automatic run_op(input int i, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic sb, output int e_acc);
    logic acc;
    int   e;
    acc = 1'b0;
    e_acc = -1;
    for (int n = 0; n < 20 && !acc; n++) begin
      drive_cycle(i, a, b, ci, sb, 1'b1, acc, e);
      if (acc) e_acc = e;
    end
    start_v = 2'b00;
  endtask

  task automatic finish_op(input int i);
    for (int n = 0; n < 30 && pending(i); n++) begin
      @(negedge clk); #1;
    end
    chk("op_complete", i, 32'(pending(i)), 32'd0);
  endtask

  task automatic lit(input int i, input logic [15:0] s, input logic c, input logic o);
    chk("lit_sum", i, 32'((i == 0) ? sum0 : sum1), 32'(s));
    chk("lit_cout", i, 32'((i == 0) ? cout0 : cout1), 32'(c));
    chk("lit_ovf", i, 32'((i == 0) ? ovf0 : ovf1), 32'(o));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int   e;
    logic acc;
    model_reset();
    last_done = '{-1, -1};
    prev_done = '{-1, -1};
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    chk("model_add", 0, 32'(model(16'd200, 16'd333, 1'b0, 1'b0)), 32'h00215);
    chk("model_sub_ovf", 0, 32'(model(16'h7FFF, 16'hFFFF, 1'b0, 1'b1)), 32'h28000);
    chk("model_wrap", 0, 32'(model(16'hFFFF, 16'h0001, 1'b0, 1'b0)), 32'h10000);

    run_op(0, 16'd200, 16'd333, 1'b0, 1'b0, e); finish_op(0); lit(0, 16'd533, 1'b0, 1'b0);
    run_op(0, 16'd0, 16'd1, 1'b1, 1'b0, e); finish_op(0); lit(0, 16'd2, 1'b0, 1'b0);
    run_op(0, 16'd200, 16'd1000, 1'b1, 1'b0, e); finish_op(0); lit(0, 16'd1201, 1'b0, 1'b0);
    run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, e); finish_op(0); lit(0, 16'h0000, 1'b1, 1'b0);
    run_op(0, 16'h7FFF, 16'hFFFF, 1'b0, 1'b1, e); finish_op(0); lit(0, 16'h8000, 1'b0, 1'b1);
    run_op(0, 16'd1000, 16'd200, 1'b1, 1'b1, e); finish_op(0); lit(0, 16'd800, 1'b1, 1'b0);

    run_op(0, 16'd5, 16'd6, 1'b0, 1'b0, e);
    drive_cycle(0, 16'd100, 16'd100, 1'b0, 1'b0, 1'b1, acc, e);
    start_v = 2'b00;
    finish_op(0); lit(0, 16'd11, 1'b0, 1'b0);

    run_op(0, 16'd3, 16'd4, 1'b0, 1'b0, e);
    run_op(0, 16'd10, 16'd3, 1'b0, 1'b1, e);
    finish_op(0); lit(0, 16'd7, 1'b1, 1'b0);
    chk("b2b_gap", 0, 32'(last_done[0] - prev_done[0]), 32'd5);

    run_op(0, 16'h1234, 16'h1111, 1'b0, 1'b0, e);
    repeat (2) begin @(negedge clk); #1; end
    rst_n = 1'b0;
    model_reset();
    @(negedge clk); #1;
    chk("rst_busy", 0, 32'(busy0), 32'd0);
    chk("rst_sum", 0, 32'(sum0), 32'd0);
    rst_n = 1'b1;
    run_op(0, 16'h1234, 16'h1111, 1'b0, 1'b0, e); finish_op(0); lit(0, 16'h2345, 1'b0, 1'b0);

    run_op(1, 16'd1, 16'd1, 1'b0, 1'b0, e); finish_op(1); lit(1, 16'd2, 1'b0, 1'b0);
    chk("n1_latency", 1, 32'(last_done[1] - e), 32'd1);
    run_op(1, 16'd5, 16'd7, 1'b0, 1'b1, e); finish_op(1); lit(1, 16'hFFFE, 1'b0, 1'b0);

    @(negedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
